icberg_pipe: RTL and testbench
==============================

# icberg_pipe

Parametrised successor to the 40-pin pass-through board model. It carries `CHANNELS` independent `WIDTH`-bit channels from board input to board output through a configurable-depth register pipeline. It adds a freeze (hold) control, a combinational legacy bypass, per-channel sticky change flags and a saturating delivered-word counter. It sits between TTL chip models wherever an inter-board connector adds pipeline delay.

## Interface
- `CHANNELS`, 16, number of channels.
- `WIDTH`, 1, bits per channel.
- `DEPTH`, 2, pipeline register stages (0 = pure combinational pass-through; legal 0..8).
- `clk` in 1: single clock; all state updates on rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `in_data` in CHANNELS*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid` in 1: `in_data` is a real sample this cycle.
- `hold` in 1: freeze all pipeline stages.
- `bypass` in 1: drive outputs combinationally from inputs.
- `clear` in 1: synchronous clear of `chg_flags` and `out_count`.
- `out_data` out CHANNELS*WIDTH: delivered word.
- `out_valid` out 1: `out_data` is a delivered sample.
- `chg_flags` out CHANNELS: sticky per-channel "value changed" flags.
- `out_count` out 16: number of valid words delivered, saturating.

## Operation
- Pipeline: stage 0 captures `{in_valid, in_data}`; stage k captures stage k-1. The last stage drives `out_data`/`out_valid`.
- `hold`=1: every stage keeps its contents; input sample that cycle is dropped; no delivery is counted.
- `bypass`=1: `out_data`=`in_data`, `out_valid`=`in_valid` combinationally. The pipeline still advances (or holds) internally, so deasserting `bypass` exposes the pipeline contents immediately.
- `DEPTH`=0: module is combinational for data/valid; `hold` has no effect on outputs; `bypass` is irrelevant.
- Delivery event: a cycle in which `out_valid`=1 and `hold`=0 (with `DEPTH`=0 or `bypass`=1: `in_valid`=1 and `hold`=0).
- On each delivery event:
  - `out_count` increments, saturating at 0xFFFF.
  - For each channel whose delivered value differs from the last delivered word (`last_word` register), set `chg_flags[c]`.
  - `last_word` loads the delivered word.
- `clear`=1 zeroes `chg_flags` and `out_count`. On the same cycle as a delivery event, the delivery wins: the count becomes 1 and the flags take that event's differences only. `last_word` is not cleared.

## Timing
- Reset (async assert, sync-safe release): all stages valid=0, data=0; `last_word`=0; `out_data`=0, `out_valid`=0, `chg_flags`=0, `out_count`=0. With `bypass`=1, outputs follow the inputs even during reset.
- Latency: a sample presented with `in_valid`=1 on edge n appears at the output after edge n+DEPTH, extended by one cycle per cycle of `hold`.
- Throughput: one word per cycle; no back-pressure.
- Reset mid-operation: all in-flight samples are discarded; none are counted.
- `hold` asserted for the full pipeline lifetime: outputs are constant; counter and flags are unchanged.
- Counter at 0xFFFF plus a delivery: stays at 0xFFFF; flags still update.
- Flags and count update on the edge that ends the delivery cycle and are visible the cycle after.

## Structure
- Package `icberg_pkg`: `COUNT_W`=16, `COUNT_MAX`, `MAX_DEPTH`=8, and a function for channel slice extraction.
- Sub-module `icberg_stage`: one `{valid, data}` register with hold and async active-low reset. Generate DEPTH instances; the `DEPTH`=0 branch is wires only.
- Top-level logic holds change detection, `last_word`, the counter and the bypass mux.

## Test plan
- Reset, then with DEPTH=2, CHANNELS=16, WIDTH=1: drive `in_data`=0xA5A5 with `in_valid`=1 at edge 1 -> `out_data`=0xA5A5, `out_valid`=1 after edge 3; `out_count`=1; `chg_flags`=0xA5A5.
- Stream 0x0001, 0x0003, 0x0003, then assert `hold` for 3 cycles mid-stream -> output frozen for 3 cycles, latency stretched by 3, final `out_count`=3, `chg_flags`=0x0003.
- `bypass`=1 with DEPTH=4 and `in_data`=0x1234 -> `out_data`=0x1234 the same cycle. Drop `bypass` -> output shows the pipeline's oldest stage.
- `clear` coincident with a delivery of 0x8000 after 0x0000 -> `out_count`=1, `chg_flags`=0x8000.
- Force the count to 0xFFFE and deliver 3 words -> `out_count`=0xFFFF, held there.
- Assert `nReset` low with 2 samples in flight -> outputs 0 immediately. After release with `in_valid`=0, `out_valid` stays 0 and `out_count`=0.

Source files
------------

// File: rtl/icberg_pkg.sv
// Shared constants and helpers for the icberg inter-board pipeline.
package icberg_pkg;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam int MAX_DEPTH = 8;

  // Widest bus the slice helper handles. CHANNELS*WIDTH must not exceed it.
  localparam int BUS_MAX = 256;

  // Returns channel c (w bits wide) of a bus, right-aligned and zero-extended.
  function automatic logic [BUS_MAX-1:0] chan_slice(input logic [BUS_MAX-1:0] bus,
                                                    input int unsigned c,
                                                    input int unsigned w);
    logic [BUS_MAX-1:0] mask;
    mask = ~({BUS_MAX{1'b1}} << w);
    return (bus >> (c * w)) & mask;
  endfunction

endpackage

// File: rtl/icberg_stage.sv
// One pipeline register holding {valid, data}; freezes while hold_i is high.
module icberg_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         hold_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next state: capture upstream unless frozen.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  // Stage register, cleared to an empty bubble on reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/icberg_pipe.sv
// Multi-channel board-to-board pass-through with configurable register delay,
// hold, combinational bypass, sticky per-channel change flags and a
// saturating delivered-word counter.
module icberg_pipe
  import icberg_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      hold,
  input  logic                      bypass,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       chg_flags,
  output logic [COUNT_W-1:0]        out_count
);

  localparam int DW = CHANNELS * WIDTH;
  localparam bit COMB_ONLY = (DEPTH == 0);

  logic          pipe_valid;
  logic [DW-1:0] pipe_data;

  generate
    if (DEPTH == 0) begin : g_wire
      assign pipe_valid = in_valid;
      assign pipe_data  = in_data;
    end else begin : g_pipe
      logic          v [DEPTH+1];
      logic [DW-1:0] d [DEPTH+1];
      assign v[0] = in_valid;
      assign d[0] = in_data;
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        icberg_stage #(.W(DW)) u_stage (
          .clk     (clk),
          .nReset  (nReset),
          .hold_i  (hold),
          .valid_i (v[k]),
          .data_i  (d[k]),
          .valid_o (v[k+1]),
          .data_o  (d[k+1])
        );
      end
      assign pipe_valid = v[DEPTH];
      assign pipe_data  = d[DEPTH];
    end
  endgenerate

  // Bypass (or a zero-depth build) routes the inputs straight to the outputs;
  // the pipeline keeps running underneath so dropping bypass shows its tail.
  logic use_in;
  assign use_in    = bypass | COMB_ONLY;
  assign out_valid = use_in ? in_valid : pipe_valid;
  assign out_data  = use_in ? in_data  : pipe_data;

  logic deliver;
  assign deliver = out_valid & ~hold;

  logic [DW-1:0]        last_word_q, last_word_d;
  logic [CHANNELS-1:0]  chg_q, chg_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [BUS_MAX-1:0]   diff_ext;
  logic [CHANNELS-1:0]  chg_now;

  assign diff_ext = BUS_MAX'(out_data ^ last_word_q);

  // Per-channel difference between the word on the output and the last delivery.
  always_comb begin
    chg_now = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chg_now[c] = |chan_slice(diff_ext, c, WIDTH);
    end
  end

  // Clear first, then let a same-cycle delivery build on the cleared values.
  always_comb begin
    count_d     = count_q;
    chg_d       = chg_q;
    last_word_d = last_word_q;
    if (clear) begin
      count_d = '0;
      chg_d   = '0;
    end
    if (deliver) begin
      last_word_d = out_data;
      chg_d       = chg_d | chg_now;
      if (count_d != COUNT_MAX) begin
        count_d = count_d + COUNT_W'(1);
      end
    end
  end

  // Delivery bookkeeping registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      last_word_q <= '0;
      chg_q       <= '0;
      count_q     <= '0;
    end else begin
      last_word_q <= last_word_d;
      chg_q       <= chg_d;
      count_q     <= count_d;
    end
  end

  assign chg_flags = chg_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_icberg_pipe.sv
// Directed bench for icberg_pipe: a DEPTH=2 and a DEPTH=4 instance share stimulus.
module tb_icberg_pipe;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        hold = 1'b0;
  logic        bypass = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] o2_data, o4_data, o2_flags, o4_flags, o2_count, o4_count;
  logic        o2_valid, o4_valid;

  int n_checks = 0;
  int n_pass = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
    $fatal(1);
  end

  icberg_pipe #(.CHANNELS(16), .WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .nReset(nReset), .in_data(in_data), .in_valid(in_valid),
    .hold(hold), .bypass(bypass), .clear(clear), .out_data(o2_data),
    .out_valid(o2_valid), .chg_flags(o2_flags), .out_count(o2_count)
  );

  icberg_pipe #(.CHANNELS(16), .WIDTH(1), .DEPTH(4)) u_d4 (
    .clk(clk), .nReset(nReset), .in_data(in_data), .in_valid(in_valid),
    .hold(hold), .bypass(bypass), .clear(clear), .out_data(o4_data),
    .out_valid(o4_valid), .chg_flags(o4_flags), .out_count(o4_count)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] din;
    logic        vin;
    logic        hld;
    logic        byp;
    logic        clr;
    logic [15:0] e_data;
    logic        e_valid;
    logic [15:0] e_count;
    logic [15:0] e_flags;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic [15:0] din, logic vin, logic hld, logic byp, logic clr,
                              logic [15:0] e_data, logic e_valid,
                              logic [15:0] e_count, logic [15:0] e_flags);
    vec_t r;
    r.din = din; r.vin = vin; r.hld = hld; r.byp = byp; r.clr = clr;
    r.e_data = e_data; r.e_valid = e_valid; r.e_count = e_count; r.e_flags = e_flags;
    return r;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic h,
                       input logic b, input logic c);
    in_data = d; in_valid = v; hold = h; bypass = b; clear = c;
  endtask

  task automatic do_reset();
    drive(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    nReset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    nReset = 1'b1;
  endtask

  // Each row: drive inputs, take one rising edge, check u_d2 1 time unit later.
  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(tbl[i].din, tbl[i].vin, tbl[i].hld, tbl[i].byp, tbl[i].clr);
      @(posedge clk); #1;
      chk($sformatf("row%0d_data", i),  32'(o2_data),  32'(tbl[i].e_data));
      chk($sformatf("row%0d_valid", i), 32'(o2_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d_count", i), 32'(o2_count), 32'(tbl[i].e_count));
      chk($sformatf("row%0d_flags", i), 32'(o2_flags), 32'(tbl[i].e_flags));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // A: first sample A5A5 through two stages, then its delivery bookkeeping.
    tbl[0]  = mk(16'hA5A5, 1, 0, 0, 0, 16'h0000, 0, 16'd0, 16'h0000);
    tbl[1]  = mk(16'h0000, 0, 0, 0, 0, 16'hA5A5, 1, 16'd0, 16'h0000);
    tbl[2]  = mk(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'd1, 16'hA5A5);
    // B: stream 1,3,(hold x3 with a dropped FFFF),3.
    tbl[3]  = mk(16'h0001, 1, 0, 0, 0, 16'h0000, 0, 16'd0, 16'h0000);
    tbl[4]  = mk(16'h0003, 1, 0, 0, 0, 16'h0001, 1, 16'd0, 16'h0000);
    tbl[5]  = mk(16'hFFFF, 1, 1, 0, 0, 16'h0001, 1, 16'd0, 16'h0000);
    tbl[6]  = mk(16'hFFFF, 1, 1, 0, 0, 16'h0001, 1, 16'd0, 16'h0000);
    tbl[7]  = mk(16'hFFFF, 1, 1, 0, 0, 16'h0001, 1, 16'd0, 16'h0000);
    tbl[8]  = mk(16'h0003, 1, 0, 0, 0, 16'h0003, 1, 16'd1, 16'h0001);
    tbl[9]  = mk(16'h0000, 0, 0, 0, 0, 16'h0003, 1, 16'd2, 16'h0003);
    tbl[10] = mk(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'd3, 16'h0003);
    tbl[11] = mk(16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'd3, 16'h0003);
    // C: deliver 0000 then 8000 with clear on the 8000 delivery cycle.
    tbl[12] = mk(16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'd3, 16'h0003);
    tbl[13] = mk(16'h8000, 1, 0, 0, 0, 16'h0000, 1, 16'd3, 16'h0003);
    tbl[14] = mk(16'h0000, 0, 0, 0, 0, 16'h8000, 1, 16'd4, 16'h0003);
    tbl[15] = mk(16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'd1, 16'h8000);
    tbl[16] = mk(16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'd0, 16'h0000);

    // Reset state, and bypass following inputs while reset is held.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_data",  32'(o2_data),  32'h0);
    chk("rst_valid", 32'(o2_valid), 32'h0);
    chk("rst_count", 32'(o2_count), 32'h0);
    chk("rst_flags", 32'(o2_flags), 32'h0);
    drive(16'h1357, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst_byp_data",  32'(o4_data),  32'h1357);
    chk("rst_byp_valid", 32'(o4_valid), 32'h1);
    drive(16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    nReset = 1'b1;

    run_rows(0, 2);
    do_reset();
    run_rows(3, 16);

    // Bypass on the DEPTH=4 instance, then expose its oldest stage.
    do_reset();
    drive(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("byp_same_cycle_data",  32'(o4_data),  32'h1234);
    chk("byp_same_cycle_valid", 32'(o4_valid), 32'h1);
    @(posedge clk); #1;
    drive(16'h5678, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bypass = 1'b0;
    #1;
    chk("byp_drop_data",  32'(o4_data),  32'h1234);
    chk("byp_drop_valid", 32'(o4_valid), 32'h1);
    chk("byp_count",      32'(o4_count), 32'd2);
    chk("byp_flags",      32'(o4_flags), 32'h567C);
    @(posedge clk); #1;
    chk("byp_next_data",  32'(o4_data),  32'h5678);
    chk("byp_next_count", 32'(o4_count), 32'd3);
    chk("byp_next_flags", 32'(o4_flags), 32'h567C);

    // Counter saturation: 65534 deliveries, then three more.
    do_reset();
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_fffe_count", 32'(o2_count), 32'hFFFE);
    chk("sat_fffe_flags", 32'(o2_flags), 32'h0);
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_ffff_count", 32'(o2_count), 32'hFFFF);
    chk("sat_ffff_flags", 32'(o2_flags), 32'h0001);

    // Reset with two samples in flight.
    drive(16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("inflight_valid", 32'(o2_valid), 32'h1);
    chk("inflight_data",  32'(o2_data),  32'hAAAA);
    in_valid = 1'b0;
    nReset = 1'b0;
    #1;
    chk("midrst_data",   32'(o2_data),  32'h0);
    chk("midrst_valid",  32'(o2_valid), 32'h0);
    chk("midrst_count",  32'(o2_count), 32'h0);
    chk("midrst_flags",  32'(o2_flags), 32'h0);
    chk("midrst_d4data", 32'(o4_data),  32'h0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_valid", 32'(o2_valid), 32'h0);
    chk("postrst_count", 32'(o2_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
